// File: rtl/mq_pkg.sv
// mq_pkg: shared constants, context state type and initial-state helper for the MQ context manager
package mq_pkg;
    localparam int NUM_STATES = 47;
    localparam int QE_W       = 16;
    localparam int IDX_W      = 6;
    localparam int NUM_CX     = 19;
    localparam int CX_W       = 5;

    localparam logic [CX_W-1:0] CX_ZC0 = 5'd0;
    localparam logic [CX_W-1:0] CX_RL  = 5'd17;
    localparam logic [CX_W-1:0] CX_UNI = 5'd18;
    localparam logic [CX_W-1:0] CX_MAX = CX_W'(NUM_CX - 1);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             mps;
    } cx_state_t;

    localparam cx_state_t ZC0_INIT = '{idx: 6'd4,  mps: 1'b0};
    localparam cx_state_t RL_INIT  = '{idx: 6'd3,  mps: 1'b0};
    localparam cx_state_t UNI_INIT = '{idx: 6'd46, mps: 1'b0};

    function automatic cx_state_t init_state(input logic [CX_W-1:0] cx);
        return (cx == CX_ZC0) ? ZC0_INIT :
               (cx == CX_RL)  ? RL_INIT  :
               (cx == CX_UNI) ? UNI_INIT : '0;
    endfunction
endpackage

// File: rtl/mq_prob_table.sv
// mq_prob_table: combinational 47-entry MQ probability ROM (Qe, next-MPS, next-LPS, switch)
module mq_prob_table
    import mq_pkg::*;
(
    input  logic [IDX_W-1:0] idx_i,
    output logic [QE_W-1:0]  qe_o,
    output logic [IDX_W-1:0] nmps_o,
    output logic [IDX_W-1:0] nlps_o,
    output logic             switch_o
);
    localparam logic [QE_W-1:0] QE [NUM_STATES] = '{
        16'h5601, 16'h3401, 16'h1801, 16'h0AC1, 16'h0521, 16'h0221, 16'h5601, 16'h5401,
        16'h4801, 16'h3801, 16'h3001, 16'h2401, 16'h1C01, 16'h1601, 16'h5601, 16'h5401,
        16'h5101, 16'h4801, 16'h3801, 16'h3401, 16'h3001, 16'h2801, 16'h2401, 16'h2201,
        16'h1C01, 16'h1801, 16'h1601, 16'h1401, 16'h1201, 16'h1101, 16'h0AC1, 16'h09C1,
        16'h08A1, 16'h0521, 16'h0441, 16'h02A1, 16'h0221, 16'h0141, 16'h0111, 16'h0085,
        16'h0049, 16'h0025, 16'h0015, 16'h0009, 16'h0005, 16'h0001, 16'h5601};
    localparam logic [IDX_W-1:0] NMPS [NUM_STATES] = '{
        6'd1,  6'd2,  6'd3,  6'd4,  6'd5,  6'd38, 6'd7,  6'd8,  6'd9,  6'd10, 6'd11, 6'd12,
        6'd13, 6'd29, 6'd15, 6'd16, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21, 6'd22, 6'd23, 6'd24,
        6'd25, 6'd26, 6'd27, 6'd28, 6'd29, 6'd30, 6'd31, 6'd32, 6'd33, 6'd34, 6'd35, 6'd36,
        6'd37, 6'd38, 6'd39, 6'd40, 6'd41, 6'd42, 6'd43, 6'd44, 6'd45, 6'd45, 6'd46};
    localparam logic [IDX_W-1:0] NLPS [NUM_STATES] = '{
        6'd1,  6'd6,  6'd9,  6'd12, 6'd29, 6'd33, 6'd6,  6'd14, 6'd14, 6'd14, 6'd17, 6'd18,
        6'd20, 6'd21, 6'd14, 6'd14, 6'd15, 6'd16, 6'd17, 6'd18, 6'd19, 6'd19, 6'd20, 6'd21,
        6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29, 6'd30, 6'd31, 6'd32, 6'd33,
        6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39, 6'd40, 6'd41, 6'd42, 6'd43, 6'd46};
    localparam logic [NUM_STATES-1:0] SWITCH = 47'h0000_0000_4041;

    assign qe_o     = QE[idx_i];
    assign nmps_o   = NMPS[idx_i];
    assign nlps_o   = NLPS[idx_i];
    assign switch_o = SWITCH[idx_i];
endmodule

// File: rtl/mq_context_manager.sv
// mq_context_manager: per-context MQ probability state lookup/update with code-block init sweep
module mq_context_manager
    import mq_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             init_i,
    output logic             init_done_o,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [CX_W-1:0]  in_cx_i,
    input  logic             in_d_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [QE_W-1:0]  out_qe_o,
    output logic             out_mps_o,
    output logic [CX_W-1:0]  out_cx_o,
    output logic [IDX_W-1:0] out_idx_o
);
    localparam logic ST_RUN  = 1'b0;
    localparam logic ST_INIT = 1'b1;

    logic             state_q, state_d;
    logic [CX_W-1:0]  cnt_q, cnt_d;
    cx_state_t        ctx_q [NUM_CX];
    cx_state_t        ctx_d [NUM_CX];
    logic             valid_q, valid_d;
    logic [QE_W-1:0]  qe_q, qe_d;
    logic             mps_q, mps_d;
    logic [CX_W-1:0]  cx_q, cx_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             done_q, done_d;

    cx_state_t        ent, upd;
    logic             cx_ok, hit, accept, sw;
    logic [QE_W-1:0]  qe;
    logic [IDX_W-1:0] nmps, nlps;

    mq_prob_table u_table (
        .idx_i   (ent.idx),
        .qe_o    (qe),
        .nmps_o  (nmps),
        .nlps_o  (nlps),
        .switch_o(sw)
    );

    assign cx_ok      = in_cx_i <= CX_MAX;
    assign ent        = cx_ok ? ctx_q[in_cx_i] : '0;
    assign hit        = in_d_i == ent.mps;
    assign upd        = '{idx: hit ? nmps : nlps, mps: ent.mps ^ (!hit && sw)};
    assign in_ready_o = (state_q == ST_RUN) && !init_i && (!valid_q || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;

    // Next state: init sweep writes one entry per cycle, otherwise commit the accepted update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctx_d   = ctx_q;
        valid_d = valid_q;
        qe_d    = qe_q;
        mps_d   = mps_q;
        cx_d    = cx_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        if (state_q == ST_INIT) begin
            ctx_d[cnt_q] = init_state(cnt_q);
            cnt_d        = cnt_q + 1'b1;
            if (cnt_q == CX_MAX) begin
                state_d = ST_RUN;
                cnt_d   = '0;
                done_d  = 1'b1;
            end
        end else if (init_i) begin
            state_d = ST_INIT;
            cnt_d   = '0;
            valid_d = 1'b0;
        end else begin
            if (valid_q && out_ready_i) valid_d = 1'b0;
            if (accept) begin
                valid_d = 1'b1;
                qe_d    = qe;
                mps_d   = hit;
                cx_d    = in_cx_i;
                idx_d   = ent.idx;
                if (cx_ok) ctx_d[in_cx_i] = upd;
            end
        end
    end

    // State registers; reset loads every context with its initial probability state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            qe_q    <= '0;
            mps_q   <= 1'b0;
            cx_q    <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            for (int k = 0; k < NUM_CX; k++) ctx_q[k] <= init_state(CX_W'(k));
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            qe_q    <= qe_d;
            mps_q   <= mps_d;
            cx_q    <= cx_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            ctx_q   <= ctx_d;
        end
    end

    // Out-of-range context ids are a protocol violation by the source
    assert property (@(posedge clk_i) disable iff (!rst_ni) accept |-> cx_ok);

    assign out_valid_o = valid_q;
    assign out_qe_o    = qe_q;
    assign out_mps_o   = mps_q;
    assign out_cx_o    = cx_q;
    assign out_idx_o   = idx_q;
    assign init_done_o = done_q;
endmodule

// File: doc/mq_context_manager.md
Name: mq_context_manager

Overview:
- Per-context probability-state manager for the MQ arithmetic coder. It sits between the bit-plane context modeller and the MQ coding core.
- Accepts (context, decision) pairs and looks up the current probability state of that context. It emits Qe and the MPS/LPS classification to the coding core, then updates the context's state index and MPS sense.
- Owns the 47-entry probability table and the per-context state array. Supports a synchronous re-initialisation sweep at each code-block start.

Parameters:
- NUM_CX, 19, number of coding contexts.
- CX_W, 5, context index width (ceil(log2(NUM_CX))).
- CX_UNI, 18, uniform context id; initial state 46, MPS 0.
- CX_RL, 17, run-length context id; initial state 3, MPS 0.
- CX_ZC0, 0, first zero-coding context id; initial state 4, MPS 0.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- init  in  1  one-cycle pulse: re-initialise all contexts (code-block start).
- init_done  out  1  one-cycle pulse when the init sweep completes.
- in_valid  in  1  decision request valid.
- in_ready  out  1  request accepted when in_valid and in_ready are both high.
- in_cx  in  CX_W  context id; must be < NUM_CX.
- in_d  in  1  decision bit.
- out_valid  out  1  coded-symbol descriptor valid.
- out_ready  in  1  coding core accepts the descriptor.
- out_qe  out  16  Qe of the context state before the update.
- out_mps  out  1  1 = decision equals the context MPS (code MPS); 0 = code LPS.
- out_cx  out  CX_W  context id echoed back.
- out_idx  out  6  state index before the update (debug/trace).

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low (rst_n).
- Reset values:
  - out_valid=0, out_qe=0, out_mps=0, out_cx=0, out_idx=0, init_done=0, FSM=RUN.
  - Every context array entry is loaded with its initial value: CX_ZC0 -> (4,0), CX_RL -> (3,0), CX_UNI -> (46,0), all others -> (0,0).
- Context array: NUM_CX entries of {idx[5:0], mps}, implemented as flops. Reads are combinational.
- FSM states: RUN, INIT.
  - RUN -> INIT on init=1. This has priority over an in_valid in the same cycle; that request is not accepted.
  - INIT writes entry k at cycle k, for k = 0..NUM_CX-1, using the reset initial values.
  - After the last write: pulse init_done and return to RUN. The sweep takes exactly NUM_CX cycles.
  - init is ignored while in INIT.
  - Entering INIT clears out_valid (any pending descriptor is dropped).
- in_ready = (FSM==RUN) && !init && (!out_valid || out_ready).
- On accept, in the same cycle:
  - Read entry e = ctx[in_cx] and look up table[e.idx].
  - Register the outputs at the next edge: out_qe = Qe[e.idx], out_mps = (in_d==e.mps), out_cx = in_cx, out_idx = e.idx, out_valid = 1.
  - If in_d == e.mps: ctx[in_cx].idx <= NMPS[e.idx].
  - Else: ctx[in_cx].idx <= NLPS[e.idx]; if SWITCH[e.idx]=1, ctx[in_cx].mps <= ~e.mps.
- Latency is 1 cycle from accept to out_valid. Throughput is 1 per cycle while out_ready=1.
- Back-to-back requests to the same context need no forwarding, because the update is committed at the accept edge.
- out_valid falls when out_valid && out_ready && no new accept. Outputs hold stable while out_valid && !out_ready.
- Boundaries:
  - State 45 on MPS stays at 45.
  - State 46 is a fixed point for both MPS and LPS.
  - in_cx >= NUM_CX is a protocol violation. The assertion fires and the array is left unmodified.
- rst_n asserted mid-sweep or mid-transfer: immediate return to reset values.

Decomposition:
- Shared package mq_pkg holds:
  - constants NUM_STATES=47, QE_W=16, IDX_W=6;
  - the initial-state constants for CX_ZC0, CX_RL and CX_UNI;
  - the typedef cx_state_t {idx, mps}.
- One sub-module, mq_prob_table: combinational 47-entry Qe/NMPS/NLPS/SWITCH ROM indexed by idx. Its contents are initialised constants, not reset-loaded.

Test Plan:
- After reset, send cx=0, d=0 -> next cycle out_qe=1313, out_mps=1, out_idx=4. Then cx=0, d=1 -> out_qe=545, out_mps=0, out_idx=5. Context 0 is now (33,0).
- cx=1, d=1 at state 0 -> out_qe=22017, out_mps=0 (LPS with switch), so cx1 becomes (1,1). Then cx=1, d=1 -> out_qe=13313, out_mps=1, out_idx=1, and cx1 becomes (2,1).
- cx=18, alternate d=0/1 for 10 requests -> every response has out_qe=22017, out_idx=46, and out_mps matches d==0.
- Streaming 8 requests with out_ready low on cycles 3-5 -> in_ready low on those cycles, outputs held stable, no loss or duplication, order preserved.
- Drive cx=0 MPS until idx reaches 45, then 3 more MPS -> out_idx stays 45, out_qe=1.
- Pulse init with a request pending on out -> out_valid=0 next cycle, in_ready=0 for 19 cycles, init_done pulses once. cx=0 then reads idx 4 again.
- Assert rst_n mid-sweep at cycle 7 -> all outputs go to 0 asynchronously, FSM=RUN, contexts hold their initial values.
